uart_rx_frame_sampler: RTL and testbench

Front end of the UART receive path: synchronizes the raw serial line, detects and qualifies the start bit, and oversamples each bit with a 3-sample majority vote. Its `Sampled_Bit` / `Deser_En` outputs drive the Rx deserializer directly: one single-cycle `Deser_En` pulse per data bit, LSB first. It checks the stop bit (and, optionally, parity) and flags frame completion or error.

---
 rtl/uart_rx_frame_sampler.sv | 175 +++++++++++++++++
 tb/tb_uart_rx_frame_sampler.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_sampler.sv
// UART receive front end: 2-flop line sync, start-bit qualification, 3-sample majority vote.
// Define UART_RX_PARITY_EN to add the optional parity bit (PAR_EN/PAR_TYP in, Par_Err out).
module uart_rx_frame_sampler #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
`ifdef UART_RX_PARITY_EN
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  Par_Err,
`endif
    output logic                  Sampled_Bit,
    output logic                  Deser_En,
    output logic                  Data_Valid,
    output logic                  Stop_Err,
    output logic                  Start_Glitch
);
    localparam int unsigned BcW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BcW-1:0] LastBit = BcW'(WIDTH - 1);
    localparam logic [PRESCALE_W-1:0] One = PRESCALE_W'(1);
    localparam logic [PRESCALE_W-1:0] Two = PRESCALE_W'(2);
    localparam logic [PRESCALE_W-1:0] ResetPrescale = PRESCALE_W'(8);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    state_e                  state_q, state_d;
    logic                    rx_meta_q, rx_s;
    logic [PRESCALE_W-1:0]   ec_q, ec_d;
    logic [PRESCALE_W-1:0]   p_q, p_d;
    logic [PRESCALE_W-1:0]   half;
    logic [BcW-1:0]          bc_q, bc_d;
    logic                    s0_q, s1_q, sampled_q;
    logic                    at_last, at_s0, at_s1, at_vote, at_use, majority;
`ifdef UART_RX_PARITY_EN
    logic                    par_en_q, par_en_d, par_typ_q, par_typ_d;
    logic                    par_acc_q, par_acc_d, par_bad;
`endif

    assign Sampled_Bit = sampled_q;

    always_comb begin
        half     = p_q >> 1;
        at_last  = (ec_q == p_q - One);
        at_s0    = (ec_q == half - One);
        at_s1    = (ec_q == half);
        at_vote  = (ec_q == half + One);
        at_use   = (ec_q == half + Two);
        majority = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);

        state_d      = state_q;
        ec_d         = at_last ? '0 : ec_q + One;
        bc_d         = bc_q;
        p_d          = p_q;
        Deser_En     = 1'b0;
        Data_Valid   = 1'b0;
        Stop_Err     = 1'b0;
        Start_Glitch = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        par_acc_d = par_acc_q;
        par_bad   = par_en_q & (par_acc_q ^ par_typ_q);
        Par_Err   = 1'b0;
`endif

        unique case (state_q)
            StIdle: begin
                ec_d = '0;
                if (!rx_s) begin
                    state_d = StStart;
                    p_d     = Prescale;
`ifdef UART_RX_PARITY_EN
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                    par_acc_d = 1'b0;
`endif
                end
            end
            StStart: begin
                // The vote is only meaningful once it has been registered for this bit.
                if (at_use && sampled_q) begin
                    Start_Glitch = 1'b1;
                    state_d      = StIdle;
                    ec_d         = '0;
                end else if (at_last) begin
                    state_d = StData;
                    bc_d    = '0;
                end
            end
            StData: begin
                Deser_En = at_use;
`ifdef UART_RX_PARITY_EN
                if (at_use) par_acc_d = par_acc_q ^ sampled_q;
`endif
                if (at_last) begin
                    bc_d = bc_q + 1'b1;
                    if (bc_q == LastBit) begin
`ifdef UART_RX_PARITY_EN
                        state_d = par_en_q ? StParity : StStop;
`else
                        state_d = StStop;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (at_use) par_acc_d = par_acc_q ^ sampled_q;
                if (at_last) state_d = StStop;
            end
`endif
            StStop: begin
                if (at_last) begin
                    state_d = StIdle;
`ifdef UART_RX_PARITY_EN
                    Data_Valid = sampled_q & ~par_bad;
                    Par_Err    = par_bad;
`else
                    Data_Valid = sampled_q;
`endif
                    Stop_Err   = ~sampled_q;
                end
            end
            default: begin
                state_d = StIdle;
                ec_d    = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_meta_q <= 1'b1;
            rx_s      <= 1'b1;
            state_q   <= StIdle;
            ec_q      <= '0;
            bc_q      <= '0;
            p_q       <= ResetPrescale;
            s0_q      <= 1'b0;
            s1_q      <= 1'b0;
            sampled_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            par_acc_q <= 1'b0;
`endif
        end else begin
            rx_meta_q <= RX_IN;
            rx_s      <= rx_meta_q;
            state_q   <= state_d;
            ec_q      <= ec_d;
            bc_q      <= bc_d;
            p_q       <= p_d;
            if (state_q != StIdle) begin
                if (at_s0)   s0_q      <= rx_s;
                if (at_s1)   s1_q      <= rx_s;
                if (at_vote) sampled_q <= majority;
            end
`ifdef UART_RX_PARITY_EN
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            par_acc_q <= par_acc_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_sampler.sv
// Scoreboard bench for uart_rx_frame_sampler: directed frames push expected pulses, a monitor pops.
`timescale 1ns/1ps
module tb_uart_rx_frame_sampler;
    localparam int W  = 8;
    localparam int PW = 6;
    localparam int KDeser  = 0;
    localparam int KValid  = 1;
    localparam int KStop   = 2;
    localparam int KGlitch = 3;
    localparam int KPar    = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          RX_IN = 1'b1;
    logic [PW-1:0] Prescale = PW'(8);
    logic          Sampled_Bit, Deser_En, Data_Valid, Stop_Err, Start_Glitch;
    logic          par_err_w;
`ifdef UART_RX_PARITY_EN
    logic          PAR_EN = 1'b0;
    logic          PAR_TYP = 1'b0;
    logic          Par_Err;
    assign par_err_w = Par_Err;
`else
    assign par_err_w = 1'b0;
`endif

    uart_rx_frame_sampler #(.WIDTH(W), .PRESCALE_W(PW)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .RX_IN        (RX_IN),
        .Prescale     (Prescale),
`ifdef UART_RX_PARITY_EN
        .PAR_EN       (PAR_EN),
        .PAR_TYP      (PAR_TYP),
        .Par_Err      (Par_Err),
`endif
        .Sampled_Bit  (Sampled_Bit),
        .Deser_En     (Deser_En),
        .Data_Valid   (Data_Valid),
        .Stop_Err     (Stop_Err),
        .Start_Glitch (Start_Glitch)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int           kind;
        int           cyc;
        logic [W-1:0] data;
    } ev_t;

    ev_t          q[$];
    int           vectors = 0;
    int           errors  = 0;
    logic [W-1:0] shreg   = '0;
    bit           done    = 1'b0;

    task automatic push(input int kind, input int c, input logic [W-1:0] d);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.data = d;
        q.push_back(e);
    endtask

    task automatic check(input int kind, input logic [W-1:0] act);
        ev_t e;
        vectors++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse: got kind=%0d at cyc %0d, required no pulse", kind, cyc);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.data != act) begin
                errors++;
                $display("FAIL pulse_kind%0d: got kind=%0d cyc=%0d data=%h, required kind=%0d cyc=%0d data=%h",
                         e.kind, kind, cyc, act, e.kind, e.cyc, e.data);
            end
        end
    endtask

    // Monitor: owns every comparison and the summary.
    initial begin
        bit rst_seen;
        rst_seen = 1'b0;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                shreg = '0;
                if (!rst_seen) begin
                    rst_seen = 1'b1;
                    vectors++;
                    if ({Sampled_Bit, Deser_En, Data_Valid, Stop_Err, Start_Glitch, par_err_w} != 6'b0) begin
                        errors++;
                        $display("FAIL reset_outputs: got %b, required 000000",
                                 {Sampled_Bit, Deser_En, Data_Valid, Stop_Err, Start_Glitch, par_err_w});
                    end
                end
            end else begin
                rst_seen = 1'b0;
            end
            if (Deser_En) begin
                check(KDeser, {{(W-1){1'b0}}, Sampled_Bit});
                shreg = {Sampled_Bit, shreg[W-1:1]};
            end
            if (Data_Valid) begin
                check(KValid, shreg);
                shreg = '0;
            end
            if (Stop_Err) begin
                check(KStop, '0);
                shreg = '0;
            end
            if (par_err_w) begin
                check(KPar, '0);
                shreg = '0;
            end
            if (Start_Glitch) begin
                check(KGlitch, '0);
                shreg = '0;
            end
            if (done) begin
                vectors++;
                if (q.size() != 0) begin
                    errors++;
                    $display("FAIL missing_pulses: got %0d still pending, required 0 (next kind=%0d cyc=%0d)",
                             q.size(), q[0].kind, q[0].cyc);
                end
                $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
                $finish;
            end
        end
    end

    // Frame: start, W data bits LSB first, optional parity, stop. Prescale is disturbed mid-frame.
    task automatic send_frame(input int p, input logic [W-1:0] d, input logic stop_b, input bit glitch,
                              input bit par_on, input logic par_b, input int end_kind);
        int n, t0, nb;
        @(posedge CLK); #1;
        Prescale = PW'(p);
        n  = cyc;
        t0 = n + 3;
        nb = par_on ? W + 3 : W + 2;
        for (int k = 0; k < W; k++) push(KDeser, t0 + (k + 1) * p + p / 2 + 2, {{(W-1){1'b0}}, d[k]});
        push(end_kind, t0 + nb * p - 1, (end_kind == KValid) ? d : '0);
        for (int i = 0; i < nb; i++) begin
            logic b;
            if (i == 0)                    b = 1'b0;
            else if (i <= W)               b = d[i-1];
            else if (par_on && i == W + 1) b = par_b;
            else                           b = stop_b;
            for (int j = 0; j < p; j++) begin
                RX_IN = (glitch && j == p / 2 + 1) ? ~b : b;
                if (i == 1 && j == 0) Prescale = (p == 8) ? PW'(16) : PW'(8);
                @(posedge CLK); #1;
            end
        end
        RX_IN    = 1'b1;
        Prescale = PW'(p);
        repeat (2 * p) @(posedge CLK);
        #1;
    endtask

    task automatic send_glitch(input int p, input int low_len);
        int n;
        @(posedge CLK); #1;
        Prescale = PW'(p);
        n = cyc;
        push(KGlitch, n + 3 + p / 2 + 2, '0);
        RX_IN = 1'b0;
        repeat (low_len) @(posedge CLK);
        #1;
        RX_IN = 1'b1;
        repeat (2 * p) @(posedge CLK);
        #1;
    endtask

    initial begin
        int n, t0;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;
        repeat (4) @(posedge CLK);
        #1;

        send_frame(8, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, KValid);
        send_glitch(16, 4);
        send_frame(8, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, KStop);
        send_frame(8, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, KValid);
        send_frame(32, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0, KValid);

        // Reset lands inside data bit 3 of 0xFF, before its Deser_En.
        @(posedge CLK); #1;
        Prescale = PW'(8);
        n  = cyc;
        t0 = n + 3;
        for (int k = 0; k < 3; k++) push(KDeser, t0 + (k + 1) * 8 + 6, {{(W-1){1'b0}}, 1'b1});
        RX_IN = 1'b0;
        repeat (8) @(posedge CLK);
        #1;
        RX_IN = 1'b1;
        repeat (27) @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        RST = 1'b1;
        repeat (16) @(posedge CLK);
        #1;
        send_frame(8, 8'h81, 1'b1, 1'b0, 1'b0, 1'b0, KValid);

`ifdef UART_RX_PARITY_EN
        PAR_EN  = 1'b1;
        PAR_TYP = 1'b0;
        send_frame(8, 8'h07, 1'b1, 1'b0, 1'b1, 1'b0, KPar);
        send_frame(8, 8'h07, 1'b1, 1'b0, 1'b1, 1'b1, KValid);
        PAR_EN  = 1'b0;
`endif

        repeat (8) @(posedge CLK);
        #1;
        done = 1'b1;
    end

endmodule
